ram_access_ctrl: RTL and testbench

//  Initiator side of the single-port RAM interface (en/rw/addr/din/dout).

---
 rtl/ram_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// ram_access_ctrl
//   Initiator side of a single-port RAM (en/rw/addr/din/dout). Accepts one
//   read or write request at a time over a valid/ready front end, drives the
//   RAM strobes, and returns read data over a valid/ready response port.
//
// Parameters
//   AW      RAM address width
//   DW      RAM data width
//   RD_LAT  RAM read latency in clocks (>=1): number of cycles ram_en=1,
//           ram_rw=0 is held before ram_dout is captured
//
// Ports
//   clk, rst_n                     clock (posedge), async active-low reset
//   req_valid/req_ready            request handshake
//   req_wr, req_addr, req_wdata    request: 1=write/0=read, address, data
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             read data, read-back mismatch flag
//   busy                           controller not idle
//   ram_en, ram_rw, ram_addr,
//   ram_din, ram_dout              RAM side (rw: 1=write, 0=read)
//
// Configuration
//   VERIFY_EN  when defined, every write is followed by a read-back of the
//              same address and answered with a response whose rsp_err flags
//              a data mismatch. When undefined, writes get no response and
//              rsp_err is tied to 0.
// -----------------------------------------------------------------------------
module ram_access_ctrl #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          ram_en,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP
  } state_t;

`ifdef VERIFY_EN
  localparam state_t S_AFTER_WR = S_RD;    // read back what was just written
`else
  localparam state_t S_AFTER_WR = S_IDLE;  // writes are fire-and-forget
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_rd_last;

  logic          r_req_ready;
  logic          r_busy;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_ram_en;
  logic          r_ram_rw;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;   // doubles as the latched write data

  // req_ready is only ever high in IDLE, so this is the accept condition.
  assign w_accept  = (r_state == S_IDLE) && req_valid && r_req_ready;
  assign w_rd_last = (r_state == S_RD) && (r_cnt == CW'(RD_LAT - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first guarantees w_state_nxt is written on
  // every path, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = req_wr ? S_WR : S_RD;
      S_WR:    w_state_nxt = S_AFTER_WR;
      S_RD:    if (w_rd_last) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read-latency counter: cleared on every entry into RD, counts while in RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_cnt <= '0;
    else if (w_state_nxt == S_RD && r_state != S_RD)  r_cnt <= '0;
    else if (r_state == S_RD)                         r_cnt <= r_cnt + CW'(1);
  end

  // Outputs are registered copies of what the next state implies, so they
  // line up with the state they describe and never glitch.
  // NOTE: datapath registers are reset too, because every output must read 0
  // while rst_n is low; this is a handful of flops, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_ram_en    <= (w_state_nxt == S_WR) || (w_state_nxt == S_RD);
      r_ram_rw    <= (w_state_nxt == S_WR);
      // Address/data only move on accept; they hold while ram_en is low.
      if (w_accept) begin
        r_ram_addr <= req_addr;
        if (req_wr) r_ram_din <= req_wdata;
      end
      if (w_rd_last) r_rsp_rdata <= ram_dout;
    end
  end

`ifdef VERIFY_EN
  logic r_wr;
  logic r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr      <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept)  r_wr      <= req_wr;
      // Plain reads never flag an error; only a write's read-back is compared.
      if (w_rd_last) r_rsp_err <= r_wr && (ram_dout != r_ram_din);
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ram_en    = r_ram_en;
  assign ram_rw    = r_ram_rw;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_access_ctrl
//   Two controller instances (RD_LAT=1 and RD_LAT=3), each attached to a
//   behavioural RAM whose read data is only correct once the read strobe has
//   been held for RD_LAT-1 prior cycles. Expected results come from a plain
//   array model of memory contents and the cycle-level latency rules.
// -----------------------------------------------------------------------------
module tb_ram_access_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_wr    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          rsp_err   [2];
  logic          busy      [2];
  logic          ram_en    [2];
  logic          ram_rw    [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_din   [2];
  logic [DW-1:0] ram_dout  [2];

  logic          stuck0;             // force bit0 of every RAM write to 0
  logic [DW-1:0] exp_mem [2][NW];    // reference memory contents
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cur_k    = 0;

  function automatic logic [DW-1:0] init_val(input int k, input int a);
    return DW'((a * 37 + k * 101 + 5) ^ (a >> 3));
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem [NW];
    int            rd_run = 0;

    initial for (int i = 0; i < NW; i++) mem[i] <= init_val(g, i);

    always @(posedge clk) begin
      if (ram_en[g] && ram_rw[g]) mem[ram_addr[g]] <= ram_din[g] & ~{{(DW-1){1'b0}}, stuck0};
      rd_run <= (ram_en[g] && !ram_rw[g]) ? rd_run + 1 : 0;
    end

    // Data is garbage (inverted) until the read strobe has been held long enough.
    assign ram_dout[g] = (ram_en[g] && !ram_rw[g] && rd_run >= LAT - 1) ?
                         mem[ram_addr[g]] : ~mem[ram_addr[g]];

    ram_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wr    (req_wr[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g]),
      .ram_en    (ram_en[g]),
      .ram_rw    (ram_rw[g]),
      .ram_addr  (ram_addr[g]),
      .ram_din   (ram_din[g]),
      .ram_dout  (ram_dout[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [dut%0d] %s: got 0x%0h expected 0x%0h at %0t", cur_k, tag, act, exp, $time);
    end
  endtask

  // Present a request, wait (bounded) for acceptance, then leave the caller
  // at #1 after the accept edge, i.e. inside cycle 1. Returns 0 on timeout.
  task automatic issue(input int k, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit rdy, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_wr[k] = wr; req_addr[k] = a; req_wdata[k] = d;
    rsp_ready[k] = rdy;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[k]) ok = 1'b1;
    end
    check("accept", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk); #1;
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic run_op(input int k, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int hold);
    bit            ok;
    bit            has_rsp;
    logic [DW-1:0] stored;
    logic [DW-1:0] exp_d;
    bit            exp_e;
    cur_k  = k;
    stored = d & ~{{(DW-1){1'b0}}, stuck0};
    if (wr) exp_mem[k][a] = stored;
    exp_d = wr ? stored : exp_mem[k][a];
    exp_e = wr && (stored != d);
`ifdef VERIFY_EN
    has_rsp = 1'b1;
`else
    has_rsp = !wr;
`endif
    issue(k, wr, a, d, hold == 0, ok);
    if (!ok) return;
    if (wr) begin
      @(negedge clk);
      check("wr_en",    32'(ram_en[k]),    32'd1);
      check("wr_rw",    32'(ram_rw[k]),    32'd1);
      check("wr_addr",  32'(ram_addr[k]),  32'(a));
      check("wr_din",   32'(ram_din[k]),   32'(d));
      check("wr_rspv",  32'(rsp_valid[k]), 32'd0);
      @(posedge clk); #1;
    end
    if (has_rsp) begin
      for (int j = 0; j < lat_of(k); j++) begin
        @(negedge clk);
        check("rd_en",   32'(ram_en[k]),    32'd1);
        check("rd_rw",   32'(ram_rw[k]),    32'd0);
        check("rd_addr", 32'(ram_addr[k]),  32'(a));
        check("rd_rspv", 32'(rsp_valid[k]), 32'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid[k]), 32'd1);
      check("rsp_rdata", 32'(rsp_rdata[k]), 32'(exp_d));
      check("rsp_err",   32'(rsp_err[k]),   32'(exp_e));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (h == hold - 1) rsp_ready[k] = 1'b1;
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid[k]), 32'd1);
        check("hold_rdata", 32'(rsp_rdata[k]), 32'(exp_d));
        check("hold_rdy",   32'(req_ready[k]), 32'd0);
        check("hold_en",    32'(ram_en[k]),    32'd0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("end_rspv",  32'(rsp_valid[k]), 32'd0);
    check("end_en",    32'(ram_en[k]),    32'd0);
    check("end_ready", 32'(req_ready[k]), 32'd1);
    check("end_busy",  32'(busy[k]),      32'd0);
  endtask

  task automatic reset_mid_read(input int k);
    bit ok;
    bit seen;
    cur_k = k;
    issue(k, 1'b0, 10'h00A, 8'h00, 1'b1, ok);
    if (!ok) return;
    @(negedge clk);
    check("pre_rst_en", 32'(ram_en[k]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_en",    32'(ram_en[k]),    32'd0);
    check("rst_rw",    32'(ram_rw[k]),    32'd0);
    check("rst_busy",  32'(busy[k]),      32'd0);
    check("rst_ready", 32'(req_ready[k]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[k]) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    stuck0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_wr[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   rsp_ready[k] = 1'b0;
      for (int i = 0; i < NW; i++) exp_mem[k][i] = init_val(k, i);
    end

    // Reset state and release timing.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cur_k = k;
      check("rst_all_outputs",
            {req_ready[k], rsp_valid[k], rsp_err[k], busy[k], ram_en[k], ram_rw[k]}, 32'd0);
      check("rst_rdata", 32'(rsp_rdata[k]), 32'd0);
      check("rst_addr",  32'(ram_addr[k]),  32'd0);
      check("rst_din",   32'(ram_din[k]),   32'd0);
    end
    #1 rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      cur_k = k;
      check("pre_edge_ready", 32'(req_ready[k]), 32'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      cur_k = k;
      check("post_rst_ready", 32'(req_ready[k]), 32'd1);
      check("post_rst_busy",  32'(busy[k]),      32'd0);
    end

    for (int k = 0; k < 2; k++) begin
      run_op(k, 1'b1, 10'h00A, 8'h14, 0);
      run_op(k, 1'b1, 10'h0FF, 8'h32, 0);
      run_op(k, 1'b0, 10'h00A, 8'h5A, 0);
      run_op(k, 1'b0, 10'h0FF, 8'h00, 0);
      run_op(k, 1'b0, 10'h3FF, 8'h00, 0);
      run_op(k, 1'b0, 10'h00A, 8'h00, 5);
      reset_mid_read(k);
      run_op(k, 1'b0, 10'h00A, 8'h00, 0);
`ifdef VERIFY_EN
      run_op(k, 1'b1, 10'h3FF, 8'hA5, 0);
      stuck0 = 1'b1;
      run_op(k, 1'b1, 10'h3FF, 8'hA5, 0);
      run_op(k, 1'b1, 10'h3FE, 8'h3C, 0);
      stuck0 = 1'b0;
`endif
      for (int n = 0; n < 30; n++) begin
        logic [AW-1:0] a;
        int            sel;
        sel = int'($urandom_range(0, 3));
        a   = (sel == 0) ? '0 : (sel == 1) ? '1 : AW'($urandom_range(0, NW - 1));
        run_op(k, 1'($urandom_range(0, 1)), a, DW'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
